// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, qualifies lock, gates sys_rst.
// Runs on the free-running reference clock.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       sys_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             sync1;
  logic             locked_s;
  logic [3:0]       retry_nxt;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  always_comb begin
    retry_nxt = retry_cnt + 4'd1;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= RESET_PLL;
      timer         <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      sys_ready     <= 1'b0;
      fault         <= 1'b0;
      retry_cnt     <= 4'd0;
      lock_loss_cnt <= 8'd0;
    end else begin
      unique case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // lock seen on the timeout edge still counts as lock
          if (locked_s) begin
            state <= STABLE;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            timer     <= '0;
            retry_cnt <= retry_nxt;
            pll_rst   <= 1'b1;
            if (retry_nxt == RETRY_MAX) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= RESET_PLL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STB_LAST) begin
            state     <= RUN;
            timer     <= '0;
            sys_rst   <= 1'b0;
            sys_ready <= 1'b1;
            retry_cnt <= 4'd0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state     <= RESET_PLL;
            timer     <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            sys_ready <= 1'b0;
            if (lock_loss_cnt != 8'hff)
              lock_loss_cnt <= lock_loss_cnt + 8'd1;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state     <= RESET_PLL;
            timer     <= '0;
            fault     <= 1'b0;
            retry_cnt <= 4'd0;
          end
        end
        default: begin
          state   <= RESET_PLL;
          timer   <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer-side controller for the PLL wrapper. It drives the PLL reset, watches the PLL `locked` output, and qualifies lock over a stability window.
- It releases the system reset only once lock is qualified. On lock loss it re-initialises the PLL; after repeated lock timeouts it latches a fault.
- Runs on the free-running reference clock, so it keeps working while the PLL outputs are dead.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=1).
- LOCK_TIMEOUT_CYCLES, 50000, max cycles in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release (>=1).
- MAX_RETRIES, 3, timeouts tolerated before FAULT (1..15).
- CNT_W, 16, width of the shared timer; must hold max(all cycle parameters).

Ports:
- refclk  input  1  reference clock (50 MHz); the single clock.
- rst  input  1  reset, asynchronous, active-high.
- locked  input  1  raw PLL locked; asynchronous to refclk.
- clear_fault  input  1  single-cycle pulse; leaves FAULT.
- pll_rst  output  1  reset to the PLL, active-high.
- sys_rst  output  1  system reset, active-high.
- sys_ready  output  1  high only in RUN.
- fault  output  1  high only in FAULT.
- retry_cnt  output  4  timeouts since the last RUN or clear.
- lock_loss_cnt  output  8  lock losses seen in RUN; saturates at 255.

Behaviour:
Synchroniser and outputs
- `locked` passes through a 2-flop synchroniser to give locked_s. Both flops reset to 0.
- All outputs are registered and updated on the edge that enters the new state; there is no combinational decode to the outputs.

Reset values (applied asynchronously while rst=1)
- State RESET_PLL, timer 0.
- pll_rst=1, sys_rst=1, sys_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0.
- Reset mid-operation forces these values immediately, without waiting for a clock edge.

States (timer clears on every state change)
- RESET_PLL:
  - pll_rst=1, sys_rst=1.
  - Timer counts up. When timer==PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE.
  - Otherwise, when timer==LOCK_TIMEOUT_CYCLES-1, increment retry_cnt. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
  - If locked_s=1 on the same edge as the timeout, locked_s wins and the state goes to STABLE.
- STABLE:
  - pll_rst=0, sys_rst=1.
  - locked_s=0 → WAIT_LOCK. The timeout timer restarts and retry_cnt is unchanged.
  - locked_s=1 with timer==LOCK_STABLE_CYCLES-1 → RUN, and retry_cnt clears to 0.
  - Otherwise the timer increments.
- RUN:
  - pll_rst=0, sys_rst=0, sys_ready=1.
  - locked_s=0 → RESET_PLL. lock_loss_cnt increments (holds at 255), and sys_rst=1, sys_ready=0 from that edge.
- FAULT:
  - pll_rst=1, sys_rst=1, fault=1.
  - clear_fault=1 → RESET_PLL with retry_cnt=0 and fault=0.
  - clear_fault is ignored in every other state.

Latency
- Take edge 1 as the first refclk edge after `locked` rises, with the state in WAIT_LOCK.
- locked_s becomes 1 at edge 2. STABLE is entered at edge 3. RUN is entered, with sys_rst falling, at edge 3+LOCK_STABLE_CYCLES.
- Lock loss in RUN: `locked` falls before edge 1 → sys_rst=1 at edge 3.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal bring-up: release rst; `locked` rises 10 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_rst falls and sys_ready rises at edge 11 after `locked` rises; retry_cnt=0.
2. Lock glitch: `locked` low for 3 cycles after 5 stable cycles, then high → no RUN during the glitch; sys_rst falls 11 edges after the final rise.
3. No lock: `locked` held 0 → two 4-cycle pll_rst pulses, retry_cnt steps 1 then 2. Then FAULT with fault=1, pll_rst=1, sys_rst=1, held indefinitely.
4. Clear fault: pulse clear_fault in FAULT → next edge fault=0, retry_cnt=0, pll_rst pulse of 4 cycles. A clear_fault pulse in RUN → no effect.
5. Lock loss in RUN: drop `locked` → sys_rst=1, sys_ready=0, pll_rst=1 at edge 3; lock_loss_cnt=1; re-lock returns to RUN. Repeat 260 times → lock_loss_cnt=255.
6. Asynchronous reset in RUN: assert rst between clock edges → sys_rst=1, pll_rst=1, sys_ready=0, counters 0 immediately with no clock edge; after release the bring-up matches scenario 1.
